// File: rtl/fu_alu_issue_arb_if.sv
// Handshake and data bundle between RCU, the ALU issue arbiter and the two ALU pipes.
interface fu_alu_issue_arb_if #(
  parameter int unsigned ENTRY_NUM_WIDTH = 2,
  parameter int unsigned ROB_INDEX_WIDTH = 4,
  parameter int unsigned PAYLOAD_WIDTH   = 128
);
  logic                       flush_i;
  logic                       in_vld_i;
  logic                       in_rdy_o;
  logic                       in_is_br_i;
  logic [ROB_INDEX_WIDTH-1:0] in_rob_index_i;
  logic [PAYLOAD_WIDTH-1:0]   in_payload_i;
  logic                       alu1_rdy_i;
  logic                       alu2_rdy_i;
  logic                       alu1_vld_o;
  logic [ROB_INDEX_WIDTH-1:0] alu1_rob_index_o;
  logic [PAYLOAD_WIDTH-1:0]   alu1_payload_o;
  logic                       alu2_vld_o;
  logic [ROB_INDEX_WIDTH-1:0] alu2_rob_index_o;
  logic [PAYLOAD_WIDTH-1:0]   alu2_payload_o;
  logic [ENTRY_NUM_WIDTH:0]   occupancy_o;

  // Arbiter side.
  modport slave (
    input  flush_i, in_vld_i, in_is_br_i, in_rob_index_i, in_payload_i,
    input  alu1_rdy_i, alu2_rdy_i,
    output in_rdy_o, alu1_vld_o, alu1_rob_index_o, alu1_payload_o,
    output alu2_vld_o, alu2_rob_index_o, alu2_payload_o, occupancy_o
  );

  // Environment side (RCU producer plus ALU consumers).
  modport master (
    output flush_i, in_vld_i, in_is_br_i, in_rob_index_i, in_payload_i,
    output alu1_rdy_i, alu2_rdy_i,
    input  in_rdy_o, alu1_vld_o, alu1_rob_index_o, alu1_payload_o,
    input  alu2_vld_o, alu2_rob_index_o, alu2_payload_o, occupancy_o
  );
endinterface

// File: rtl/fu_alu_issue_arb.sv
// In-order ALU issue queue: buffers RCU uops and dispatches up to two per cycle to alu1/alu2.
// Branches only go to alu1; a younger op never overtakes the head.
module fu_alu_issue_arb #(
  parameter int unsigned ENTRY_NUM       = 4,
  parameter int unsigned ENTRY_NUM_WIDTH = 2,
  parameter int unsigned ROB_INDEX_WIDTH = 4,
  parameter int unsigned PAYLOAD_WIDTH   = 128
) (
  input logic              clk,
  input logic              rstn,  // synchronous, active-high
  fu_alu_issue_arb_if.slave bus
);

  localparam int unsigned PtrW = ENTRY_NUM_WIDTH + 1;

  logic [PtrW-1:0]            head_q, head_d, tail_q, tail_d, count;
  logic [ENTRY_NUM-1:0]       is_br_q;
  logic [ROB_INDEX_WIDTH-1:0] rob_q [ENTRY_NUM];
  logic [PAYLOAD_WIDTH-1:0]   pay_q [ENTRY_NUM];

  logic [ENTRY_NUM_WIDTH-1:0] a_idx, b_idx, alu2_idx;
  logic                       a_vld, b_vld, push;
  logic                       a_to_alu1, a_to_alu2, b_to_alu2;
  logic                       issue1, issue2;
  logic [1:0]                 pop;

  logic                       alu1_vld_q, alu1_vld_d, alu2_vld_q, alu2_vld_d;
  logic [ROB_INDEX_WIDTH-1:0] alu1_rob_q, alu1_rob_d, alu2_rob_q, alu2_rob_d;
  logic [PAYLOAD_WIDTH-1:0]   alu1_pay_q, alu1_pay_d, alu2_pay_q, alu2_pay_d;

  // Wrap bit in the pointer MSB makes full/empty unambiguous.
  assign count = tail_q - head_q;
  assign a_idx = head_q[ENTRY_NUM_WIDTH-1:0];
  assign b_idx = a_idx + ENTRY_NUM_WIDTH'(1);
  assign a_vld = (count != '0);
  assign b_vld = (count >= PtrW'(2));

  // Ready is from registered occupancy only; a same-cycle pop does not free a slot.
  assign bus.in_rdy_o = (count < PtrW'(ENTRY_NUM)) & ~bus.flush_i;
  assign push         = bus.in_vld_i & bus.in_rdy_o;

  // Oldest-first selection; B only follows A, and branches are kept off alu2.
  always_comb begin
    a_to_alu1 = bus.alu1_rdy_i & a_vld;
    b_to_alu2 = a_to_alu1 & b_vld & bus.alu2_rdy_i & ~is_br_q[b_idx];
    a_to_alu2 = ~bus.alu1_rdy_i & a_vld & bus.alu2_rdy_i & ~is_br_q[a_idx];
    pop       = {1'b0, a_to_alu1 | a_to_alu2} + {1'b0, b_to_alu2};
    alu2_idx  = b_to_alu2 ? b_idx : a_idx;
    issue1    = a_to_alu1 & ~bus.flush_i;
    issue2    = (a_to_alu2 | b_to_alu2) & ~bus.flush_i;
  end

  // Next-state for pointers and the registered request stage; flush wins over everything.
  always_comb begin
    head_d     = head_q + PtrW'(pop);
    tail_d     = tail_q + PtrW'(push);
    alu1_vld_d = issue1;
    alu2_vld_d = issue2;
    alu1_rob_d = alu1_rob_q;
    alu1_pay_d = alu1_pay_q;
    alu2_rob_d = alu2_rob_q;
    alu2_pay_d = alu2_pay_q;
    if (issue1) begin
      alu1_rob_d = rob_q[a_idx];
      alu1_pay_d = pay_q[a_idx];
    end
    if (issue2) begin
      alu2_rob_d = rob_q[alu2_idx];
      alu2_pay_d = pay_q[alu2_idx];
    end
    if (bus.flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      head_q     <= '0;
      tail_q     <= '0;
      alu1_vld_q <= 1'b0;
      alu2_vld_q <= 1'b0;
      alu1_rob_q <= '0;
      alu2_rob_q <= '0;
      alu1_pay_q <= '0;
      alu2_pay_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      alu1_vld_q <= alu1_vld_d;
      alu2_vld_q <= alu2_vld_d;
      alu1_rob_q <= alu1_rob_d;
      alu2_rob_q <= alu2_rob_d;
      alu1_pay_q <= alu1_pay_d;
      alu2_pay_q <= alu2_pay_d;
    end
  end

  // Entry storage; contents are only meaningful between head and tail, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      is_br_q[tail_q[ENTRY_NUM_WIDTH-1:0]] <= bus.in_is_br_i;
      rob_q[tail_q[ENTRY_NUM_WIDTH-1:0]]   <= bus.in_rob_index_i;
      pay_q[tail_q[ENTRY_NUM_WIDTH-1:0]]   <= bus.in_payload_i;
    end
  end

  assign bus.alu1_vld_o       = alu1_vld_q;
  assign bus.alu1_rob_index_o = alu1_rob_q;
  assign bus.alu1_payload_o   = alu1_pay_q;
  assign bus.alu2_vld_o       = alu2_vld_q;
  assign bus.alu2_rob_index_o = alu2_rob_q;
  assign bus.alu2_payload_o   = alu2_pay_q;
  assign bus.occupancy_o      = count;

endmodule

// File: tb/tb_fu_alu_issue_arb.sv
// Bench for fu_alu_issue_arb: directed scenarios followed by random traffic, checked every
// cycle against a queue-based reference of the issue rules.
module tb_fu_alu_issue_arb;

  typedef struct packed {
    logic [3:0]   rob;
    logic         br;
    logic [127:0] pay;
  } op_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  op_t          q[$];
  logic         e1v, e2v;
  logic [3:0]   e1r, e2r;
  logic [127:0] e1p, e2p;

  fu_alu_issue_arb_if bus ();

  fu_alu_issue_arb dut (
    .clk  (clk),
    .rstn (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict the edge from the queue model, then compare outputs.
  task automatic step(input logic r, input logic f, input logic v, input logic br,
                      input logic [3:0] rob, input logic a1, input logic a2);
    logic [127:0] pay;
    op_t          o;
    int           n;
    pay = {$urandom, $urandom, $urandom, $urandom};
    rst                = r;
    bus.flush_i        = f;
    bus.in_vld_i       = v;
    bus.in_is_br_i     = br;
    bus.in_rob_index_i = rob;
    bus.in_payload_i   = pay;
    bus.alu1_rdy_i     = a1;
    bus.alu2_rdy_i     = a2;
    #1;
    n = q.size();
    if (!r) chk("in_rdy", bus.in_rdy_o, 128'((n < 4) && !f));
    e1v = 1'b0;
    e2v = 1'b0;
    if (r) begin
      q.delete();
      e1r = '0; e2r = '0; e1p = '0; e2p = '0;
    end else if (f) begin
      q.delete();
    end else begin
      if (a1 && n >= 1) begin
        e1v = 1'b1; e1r = q[0].rob; e1p = q[0].pay;
        if (n >= 2 && a2 && !q[1].br) begin
          e2v = 1'b1; e2r = q[1].rob; e2p = q[1].pay;
        end
      end else if (!a1 && a2 && n >= 1 && !q[0].br) begin
        e2v = 1'b1; e2r = q[0].rob; e2p = q[0].pay;
      end
      if (e1v) void'(q.pop_front());
      if (e2v) void'(q.pop_front());
      if (v && n < 4) begin
        o = '{rob: rob, br: br, pay: pay};
        q.push_back(o);
      end
    end
    @(posedge clk);
    #1;
    chk("alu1_vld", bus.alu1_vld_o, e1v);
    chk("alu2_vld", bus.alu2_vld_o, e2v);
    chk("alu1_rob", bus.alu1_rob_index_o, e1r);
    chk("alu2_rob", bus.alu2_rob_index_o, e2r);
    chk("alu1_pay", bus.alu1_payload_o, e1p);
    chk("alu2_pay", bus.alu2_payload_o, e2p);
    chk("occupancy", bus.occupancy_o, 128'(q.size()));
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 1, 0, 9, 1, 1);
    // Basic issue: R1, R2 back to back with both pipes ready
    step(0, 0, 1, 0, 1, 1, 1);
    step(0, 0, 1, 0, 2, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    // R3, R4 buffered, then dual issue in one cycle
    step(0, 0, 1, 0, 3, 0, 0);
    step(0, 0, 1, 0, 4, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    // Branch steering: rob 5 to alu2, branch rob 6 waits for alu1
    step(0, 0, 1, 0, 5, 0, 0);
    step(0, 0, 1, 1, 6, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    // Order hold: branch at head blocks the younger op
    step(0, 0, 1, 1, 7, 0, 0);
    step(0, 0, 1, 0, 8, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    // Full, refused fifth push, then refill across pointer wrap
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 4'(9 + i), 0, 0);
    step(0, 0, 1, 0, 13, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, logic'(i == 2), 4'(i), 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1);
    // Flush with entries queued, a selection in flight and a push offered
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'(1 + i), 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 15, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1);
    // Reset mid-stream with two entries left and alu1 request pending
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'(4 + i), 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 12, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    // Random traffic with occasional flush and reset
    for (int i = 0; i < 500; i++) begin
      step(logic'($urandom_range(0, 80) == 0), logic'($urandom_range(0, 30) == 0),
           logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0),
           4'($urandom), logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) != 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
